// File: rtl/float_pkg.sv
// Shared constants for the pipelined floating-point adder/subtractor.
// Holds the default field widths and the constants derived from them
// (word width, exponent bias, all-ones exponent, canonical quiet NaN),
// the bit positions inside the 4-bit flags word, and the pipeline latency.
// No ports; imported by the datapath modules and the bench.
package float_pkg;

  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;
  localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

  localparam logic [DEF_EXP_W-1:0] DEF_EXP_ONES = '1;
  localparam logic [DEF_W-1:0]     DEF_QNAN     =
    {1'b0, DEF_EXP_ONES, 1'b1, {(DEF_MAN_W-1){1'b0}}};

  // flags = {nan, overflow, underflow, zero}
  localparam int FLAG_W    = 4;
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  // Register stages between the input sample and the output register.
  localparam int LATENCY = 4;

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter.
// Ports:
//   vec   : WIDTH-bit input vector
//   count : number of zeros above the most significant set bit
//           (WIDTH when vec is all zeros)
module float_lzc #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0]           vec,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        count = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/float_addsub_pipe.sv
// Pipelined floating-point add/subtract, {sign, exp, man} format,
// round to nearest even, subnormals flushed to zero.
// A sample taken at an enabled edge appears on the outputs after the
// fourth following enabled edge.
// Ports:
//   clock     : sole clock, rising edge
//   rst       : synchronous active-high reset (wins over ce)
//   ce        : pipeline advance enable, 0 freezes everything
//   in_valid  : adata/bdata/op qualify this cycle
//   adata     : operand A
//   bdata     : operand B
//   op        : 0 = A+B, 1 = A-B
//   out_valid : cdata/flags qualify this cycle
//   cdata     : result word
//   flags     : {nan, overflow, underflow, zero}, 0 when out_valid=0
module float_addsub_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [EXP_W+MAN_W:0]   adata,
  input  logic [EXP_W+MAN_W:0]   bdata,
  input  logic                   op,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   cdata,
  output logic [FLAG_W-1:0]      flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;          // significand with hidden bit
  localparam int AW    = MAN_W + 4;          // significand + guard/round/sticky
  localparam int SW    = MAN_W + 5;          // aligned width + carry-out
  localparam int LZW   = $clog2(SW + 1);
  localparam int XW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0]  EXP_MIN  = XW'(1);
  localparam logic signed [XW-1:0]  EXP_MAX  = XW'((1 << EXP_W) - 2);

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  logic [LATENCY:1]   valid_reg;

  // Side-band carried unchanged through the stages; index = stage number.
  logic               sb_special_reg [1:LATENCY];
  logic [W-1:0]       sb_word_reg    [1:LATENCY];
  logic               sb_nan_reg     [1:LATENCY];
  logic               sb_sign_reg    [1:LATENCY];
  logic               sb_eff_sub_reg [1:LATENCY];
  logic [EXP_W-1:0]   sb_exp_reg     [1:LATENCY];

  logic [SIG_W-1:0]   s1_sig_l_reg;
  logic [SIG_W-1:0]   s1_sig_s_reg;
  logic [EXP_W-1:0]   s1_delta_reg;
  logic [AW-1:0]      s2_sig_l_reg;
  logic [AW-1:0]      s2_sig_s_reg;
  logic [SW-1:0]      s3_sum_reg;
  logic [SW-1:0]      s4_sum_reg;
  logic [LZW-1:0]     s4_lz_reg;

  // ---------------------------------------------------------------------
  // Stage 1: unpack, classify, order by magnitude
  // ---------------------------------------------------------------------
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [W-2:0]       a_mag, b_mag;
  logic               a_first;
  logic [SIG_W-1:0]   a_sig, b_sig;
  logic               special_next;
  logic [W-1:0]       special_word_next;
  logic               special_nan_next;

  assign a_sign = adata[W-1];
  assign b_sign = bdata[W-1] ^ op;     // subtraction flips B's sign
  assign a_exp  = adata[W-2:MAN_W];
  assign b_exp  = bdata[W-2:MAN_W];
  assign a_man  = adata[MAN_W-1:0];
  assign b_man  = bdata[MAN_W-1:0];

  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);

  // Flushed subnormals must compare as zero, hence the masking.
  assign a_mag   = a_zero ? '0 : adata[W-2:0];
  assign b_mag   = b_zero ? '0 : bdata[W-2:0];
  assign a_first = (a_mag >= b_mag);

  assign a_sig = a_zero ? '0 : {1'b1, a_man};
  assign b_sig = b_zero ? '0 : {1'b1, b_man};

  always_comb begin
    special_next      = 1'b0;
    special_word_next = '0;
    special_nan_next  = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      special_next      = 1'b1;
      special_word_next = QNAN;
      special_nan_next  = 1'b1;
    end else if (a_inf) begin
      special_next      = 1'b1;
      special_word_next = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      special_next      = 1'b1;
      special_word_next = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: align the smaller significand with guard/round/sticky
  // ---------------------------------------------------------------------
  logic [AW-1:0] align_ext;
  logic [AW-1:0] lost_mask;
  logic [AW-1:0] aligned_next;

  always_comb begin
    align_ext = {s1_sig_s_reg, 3'b000};
    lost_mask = ~({AW{1'b1}} << s1_delta_reg);
    if (32'(s1_delta_reg) >= 32'(MAN_W + 3)) begin
      // Everything lands below the round bit: only stickiness survives.
      aligned_next = {{(AW-1){1'b0}}, |s1_sig_s_reg};
    end else begin
      aligned_next = (align_ext >> s1_delta_reg)
                   | {{(AW-1){1'b0}}, |(align_ext & lost_mask)};
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: add or subtract (larger minus smaller never goes negative)
  // ---------------------------------------------------------------------
  logic [SW-1:0] sum_next;

  assign sum_next = sb_eff_sub_reg[2] ? ({1'b0, s2_sig_l_reg} - {1'b0, s2_sig_s_reg})
                                      : ({1'b0, s2_sig_l_reg} + {1'b0, s2_sig_s_reg});

  // Leading-zero count of the raw sum, registered into stage 4.
  logic [LZW-1:0] lz_next;

  float_lzc #(.WIDTH(SW)) u_lzc (
    .vec   (s3_sum_reg),
    .count (lz_next)
  );

  // ---------------------------------------------------------------------
  // Output stage: normalise, round, pack, classify
  // ---------------------------------------------------------------------
  // Shifting left by the LZC puts the leading one at the top bit for every
  // case, including carry-out (lz=0), so one extraction serves all paths;
  // the exponent gains 1 for the carry position and loses lz.
  logic [SW-1:0]           norm;
  logic [SIG_W-1:0]        sig_pre;
  logic                    guard_bit, sticky_bit, round_up;
  logic [SIG_W:0]          sig_rnd;
  logic                    rnd_carry;
  logic [MAN_W-1:0]        man_out;
  logic signed [XW-1:0]    exp_norm, exp_final;
  logic [W-1:0]            res_word;
  logic [FLAG_W-1:0]       res_flags;

  assign norm       = s4_sum_reg << s4_lz_reg;
  assign sig_pre    = norm[SW-1:4];
  assign guard_bit  = norm[3];
  assign sticky_bit = |norm[2:0];
  assign round_up   = guard_bit & (sticky_bit | sig_pre[0]);
  assign sig_rnd    = {1'b0, sig_pre} + {{SIG_W{1'b0}}, round_up};
  assign rnd_carry  = sig_rnd[SIG_W];
  assign man_out    = rnd_carry ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];

  assign exp_norm  = $signed({{(XW-EXP_W){1'b0}}, sb_exp_reg[4]}) + EXP_MIN
                   - $signed({{(XW-LZW){1'b0}}, s4_lz_reg});
  assign exp_final = exp_norm + $signed({{(XW-1){1'b0}}, rnd_carry});

  always_comb begin
    res_word  = '0;
    res_flags = '0;
    if (sb_special_reg[4]) begin
      res_word            = sb_word_reg[4];
      res_flags[FLAG_NAN] = sb_nan_reg[4];
    end else if (s4_sum_reg == '0) begin
      // Cancellation gives +0; same-sign zeros keep their sign.
      res_word             = {sb_sign_reg[4] & ~sb_eff_sub_reg[4], {(W-1){1'b0}}};
      res_flags[FLAG_ZERO] = 1'b1;
    end else if (exp_final < EXP_MIN) begin
      res_word             = {sb_sign_reg[4], {(W-1){1'b0}}};
      res_flags[FLAG_UNF]  = 1'b1;
      res_flags[FLAG_ZERO] = 1'b1;
    end else if (exp_final > EXP_MAX) begin
      res_word            = {sb_sign_reg[4], EXP_ONES, {MAN_W{1'b0}}};
      res_flags[FLAG_OVF] = 1'b1;
    end else begin
      res_word = {sb_sign_reg[4], exp_final[EXP_W-1:0], man_out};
    end
  end

  // ---------------------------------------------------------------------
  // Control path: valid bits and output register (reset overrides ce)
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      valid_reg <= '0;
      out_valid <= 1'b0;
      cdata     <= '0;
      flags     <= '0;
    end else if (ce) begin
      valid_reg <= {valid_reg[LATENCY-1:1], in_valid};
      out_valid <= valid_reg[LATENCY];
      cdata     <= valid_reg[LATENCY] ? res_word  : '0;
      flags     <= valid_reg[LATENCY] ? res_flags : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers: qualified by the valid bits, so no reset needed
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (ce) begin
      sb_special_reg[1] <= special_next;
      sb_word_reg[1]    <= special_word_next;
      sb_nan_reg[1]     <= special_nan_next;
      sb_sign_reg[1]    <= a_first ? a_sign : b_sign;
      sb_eff_sub_reg[1] <= a_sign ^ b_sign;
      sb_exp_reg[1]     <= a_first ? a_exp : b_exp;
      for (int i = LATENCY; i >= 2; i--) begin
        sb_special_reg[i] <= sb_special_reg[i-1];
        sb_word_reg[i]    <= sb_word_reg[i-1];
        sb_nan_reg[i]     <= sb_nan_reg[i-1];
        sb_sign_reg[i]    <= sb_sign_reg[i-1];
        sb_eff_sub_reg[i] <= sb_eff_sub_reg[i-1];
        sb_exp_reg[i]     <= sb_exp_reg[i-1];
      end

      s1_sig_l_reg <= a_first ? a_sig : b_sig;
      s1_sig_s_reg <= a_first ? b_sig : a_sig;
      s1_delta_reg <= a_first ? (a_exp - b_exp) : (b_exp - a_exp);

      s2_sig_l_reg <= {s1_sig_l_reg, 3'b000};
      s2_sig_s_reg <= aligned_next;

      s3_sum_reg   <= sum_next;

      s4_sum_reg   <= s3_sum_reg;
      s4_lz_reg    <= lz_next;
    end
  end

endmodule
